// File: rtl/dmem_ctrl.sv
// Byte-addressed data memory behind a valid/ready request/response pair.
// Fixed single-cycle response latency, alignment/range checking, saturating error counter.
module dmem_ctrl #(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int unsigned ERRCNT_W    = 8
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [31:0]         req_addr,
  input  logic                req_write,
  input  logic [31:0]         req_wdata,
  input  logic [1:0]          req_size,
  input  logic                req_sign_ext,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [31:0]         rsp_rdata,
  output logic                rsp_error,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);

  typedef enum logic {IDLE, RESP} state_e;

  state_e                state_q, state_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  error_q, error_d;
  logic [ERRCNT_W-1:0]   err_count_q, err_count_d;

  logic [7:0]            mem_q [DEPTH_BYTES];

  logic [AW-1:0]         idx;
  logic                  in_range;
  logic                  misaligned;
  logic                  req_err;
  logic                  accept;
  logic [31:0]           load_word;
  logic [7:0]            load_byte;
  logic [15:0]           load_half;
  logic [31:0]           load_ext;

  assign idx       = req_addr[AW-1:0];
  // BASE_ADDR is aligned to DEPTH_BYTES, so range check is an upper-bits compare
  assign in_range  = (req_addr[31:AW] == BASE_ADDR[31:AW]);

  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = (req_addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  assign req_err   = (req_size == 2'b11) || misaligned || !in_range;
  assign rsp_valid = (state_q == RESP);
  assign req_ready = !rsp_valid || rsp_ready;
  assign accept    = req_valid && req_ready;

  assign load_word = {mem_q[{idx[AW-1:2], 2'b11}], mem_q[{idx[AW-1:2], 2'b10}],
                      mem_q[{idx[AW-1:2], 2'b01}], mem_q[{idx[AW-1:2], 2'b00}]};

  always_comb begin
    load_byte = load_word[7:0];
    case (idx[1:0])
      2'b00: load_byte = load_word[7:0];
      2'b01: load_byte = load_word[15:8];
      2'b10: load_byte = load_word[23:16];
      2'b11: load_byte = load_word[31:24];
    endcase
    load_half = idx[1] ? load_word[31:16] : load_word[15:0];
  end

  always_comb begin
    load_ext = load_word;
    case (req_size)
      2'b00:   load_ext = {{24{req_sign_ext & load_byte[7]}}, load_byte};
      2'b01:   load_ext = {{16{req_sign_ext & load_half[15]}}, load_half};
      default: load_ext = load_word;
    endcase
  end

  // Memory has no reset; writes are suppressed while reset_n is low
  always_ff @(posedge clock) begin
    if (reset_n && accept && req_write && !req_err) begin
      case (req_size)
        2'b00: mem_q[idx] <= req_wdata[7:0];
        2'b01: begin
          mem_q[{idx[AW-1:1], 1'b0}] <= req_wdata[7:0];
          mem_q[{idx[AW-1:1], 1'b1}] <= req_wdata[15:8];
        end
        2'b10: begin
          mem_q[{idx[AW-1:2], 2'b00}] <= req_wdata[7:0];
          mem_q[{idx[AW-1:2], 2'b01}] <= req_wdata[15:8];
          mem_q[{idx[AW-1:2], 2'b10}] <= req_wdata[23:16];
          mem_q[{idx[AW-1:2], 2'b11}] <= req_wdata[31:24];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    rdata_d     = rdata_q;
    error_d     = error_q;
    err_count_d = err_count_q;
    if (accept) begin
      state_d = RESP;
      error_d = req_err;
      rdata_d = (req_err || req_write) ? '0 : load_ext;
      if (req_err && (err_count_q != '1)) begin
        err_count_d = err_count_q + ERRCNT_W'(1);
      end
    end else if (rsp_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rdata_q     <= '0;
      error_q     <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      rdata_q     <= rdata_d;
      error_q     <= error_d;
      err_count_q <= err_count_d;
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_error = error_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed scenarios plus randomized traffic
// compared against a byte-array reference model.
module tb_dmem_ctrl;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h1000_0000;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic        req_valid, req_ready, req_write, req_sign_ext;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [31:0] rsp_rdata;
  logic [7:0]  err_count;

  logic        s_valid, s_ready, s_write, s_sext, s_rsp_valid, s_rsp_ready, s_rsp_error;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [1:0]  s_size;
  logic [1:0]  s_err_count;

  dmem_ctrl #(.DEPTH_BYTES(DEPTH), .BASE_ADDR(BASE), .ERRCNT_W(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_size(req_size),
    .req_sign_ext(req_sign_ext), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error), .err_count(err_count)
  );

  dmem_ctrl #(.DEPTH_BYTES(DEPTH), .BASE_ADDR(BASE), .ERRCNT_W(2)) dut_sat (
    .clock(clock), .reset_n(reset_n),
    .req_valid(s_valid), .req_ready(s_ready), .req_addr(s_addr),
    .req_write(s_write), .req_wdata(s_wdata), .req_size(s_size),
    .req_sign_ext(s_sext), .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready),
    .rsp_rdata(s_rdata), .rsp_error(s_rsp_error), .err_count(s_err_count)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] model_mem [DEPTH];
  int         model_err;

  // Reference: decides the outcome from the access rules, updates the byte array.
  task automatic model_step(input bit w, input logic [31:0] a, input logic [31:0] d,
                            input logic [1:0] s, input bit se,
                            output bit e, output logic [31:0] rd);
    longint unsigned ua;
    longint unsigned v;
    int n;
    int off;
    logic [31:0] ones;
    ua   = a;
    ones = '1;
    rd   = '0;
    e = (s == 2'd3) || (s == 2'd1 && (ua % 2) != 0) || (s == 2'd2 && (ua % 4) != 0) ||
        (ua < BASE) || (ua >= longint'(BASE) + DEPTH);
    if (e) begin
      if (model_err < 255) model_err++;
      return;
    end
    n   = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    off = int'(ua - BASE);
    if (w) begin
      for (int i = 0; i < n; i++) model_mem[off + i] = 8'((d >> (8 * i)) & 32'hFF);
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) v = v | (longint'(model_mem[off + i]) << (8 * i));
      rd = v[31:0];
      if (se && n < 4 && ((v >> (8 * n - 1)) & 1) == 1) rd = rd | (ones << (8 * n));
    end
  endtask

  task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s, input bit se,
                       output bit e, output logic [31:0] rd);
    req_valid    = 1'b1;
    req_write    = w;
    req_addr     = a;
    req_wdata    = d;
    req_size     = s;
    req_sign_ext = se;
    model_step(w, a, d, s, se, e, rd);
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    req_write = 1'b0; req_addr = '0; req_wdata = '0; req_size = '0; req_sign_ext = 1'b0;
    s_valid = 1'b0; s_write = 1'b0; s_addr = BASE; s_wdata = '0; s_size = 2'd3;
    s_sext = 1'b0; s_rsp_ready = 1'b1;
    model_err = 0;
    repeat (3) @(posedge clock);
    #1;
    tests_run++;
    if ({rsp_valid, rsp_error, rsp_rdata, err_count} !== 42'd0) begin
      tests_failed++;
      $display("FAIL reset_state got valid=%b err=%b rdata=%h cnt=%0d exp all zero",
               rsp_valid, rsp_error, rsp_rdata, err_count);
    end
    reset_n = 1'b1;
    #1;
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready got %b exp 1", req_ready);
    end
  endtask

  task automatic init_mem();
    bit e;
    logic [31:0] rd;
    for (int unsigned i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
    for (int unsigned i = 0; i < DEPTH / 4; i++) issue(1'b1, BASE + 4 * i, '0, 2'd2, 1'b0, e, rd);
  endtask

  task automatic test_word_and_ext();
    bit e;
    logic [31:0] rd;
    logic [31:0] exp_v [5];
    logic [31:0] ad [5];
    logic [1:0]  sz [5];
    bit          sx [5];
    issue(1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 2'd2, 1'b0, e, rd);
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL sw_resp got valid=%b err=%b rdata=%h exp 1/0/0", rsp_valid, rsp_error, rsp_rdata);
    end
    issue(1'b0, 32'h1000_0010, '0, 2'd2, 1'b0, e, rd);
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_rdata !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL lw_resp got valid=%b err=%b rdata=%h exp 1/0/deadbeef", rsp_valid, rsp_error, rsp_rdata);
    end
    ad[0] = 32'h1000_0013; sz[0] = 2'd0; sx[0] = 1'b1; exp_v[0] = 32'hFFFF_FFDE;
    ad[1] = 32'h1000_0013; sz[1] = 2'd0; sx[1] = 1'b0; exp_v[1] = 32'h0000_00DE;
    ad[2] = 32'h1000_0012; sz[2] = 2'd1; sx[2] = 1'b1; exp_v[2] = 32'hFFFF_DEAD;
    ad[3] = 32'h1000_0012; sz[3] = 2'd1; sx[3] = 1'b0; exp_v[3] = 32'h0000_DEAD;
    ad[4] = 32'h1000_0010; sz[4] = 2'd2; sx[4] = 1'b1; exp_v[4] = 32'hDEAD_BEEF;
    for (int k = 0; k < 5; k++) begin
      issue(1'b0, ad[k], '0, sz[k], sx[k], e, rd);
      tests_run++;
      if (rsp_error !== 1'b0 || rsp_rdata !== exp_v[k]) begin
        tests_failed++;
        $display("FAIL load_ext[%0d] got err=%b rdata=%h exp 0/%h", k, rsp_error, rsp_rdata, exp_v[k]);
      end
    end
    issue(1'b1, 32'h1000_0011, 32'h0000_0055, 2'd0, 1'b0, e, rd);
    issue(1'b0, 32'h1000_0010, '0, 2'd2, 1'b0, e, rd);
    tests_run++;
    if (rsp_rdata !== 32'hDEAD_55EF) begin
      tests_failed++;
      $display("FAIL sb_merge got %h exp dead55ef", rsp_rdata);
    end
  endtask

  task automatic test_errors();
    bit e;
    logic [31:0] rd;
    logic [31:0] ad [4];
    logic [1:0]  sz [4];
    bit          wr [4];
    ad[0] = 32'h1000_0002; sz[0] = 2'd2; wr[0] = 1'b0;
    ad[1] = 32'h1000_0001; sz[1] = 2'd1; wr[1] = 1'b1;
    ad[2] = 32'h1000_0000; sz[2] = 2'd3; wr[2] = 1'b0;
    ad[3] = 32'h1000_0400; sz[3] = 2'd2; wr[3] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      issue(wr[k], ad[k], 32'h1234_5678, sz[k], 1'b0, e, rd);
      tests_run++;
      if (rsp_error !== 1'b1 || rsp_rdata !== 32'h0 || err_count !== 8'(k + 1)) begin
        tests_failed++;
        $display("FAIL err_case[%0d] got err=%b rdata=%h cnt=%0d exp 1/0/%0d",
                 k, rsp_error, rsp_rdata, err_count, k + 1);
      end
    end
    issue(1'b0, 32'h1000_0000, '0, 2'd2, 1'b0, e, rd);
    tests_run++;
    if (rsp_rdata !== 32'h0 || rsp_error !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_no_write got err=%b rdata=%h exp 0/0", rsp_error, rsp_rdata);
    end
  endtask

  task automatic test_backpressure();
    bit e;
    logic [31:0] rd;
    issue(1'b0, 32'h1000_0010, '0, 2'd2, 1'b0, e, rd);
    rsp_ready    = 1'b0;
    req_valid    = 1'b1;
    req_write    = 1'b0;
    req_addr     = 32'h1000_0000;
    req_size     = 2'd2;
    req_sign_ext = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      tests_run++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_55EF || rsp_error !== 1'b0 || req_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d] got valid=%b rdata=%h err=%b ready=%b exp 1/dead55ef/0/0",
                 k, rsp_valid, rsp_rdata, rsp_error, req_ready);
      end
    end
    rsp_ready = 1'b1;
    #1;
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_release_ready got %b exp 1", req_ready);
    end
    model_step(1'b0, 32'h1000_0000, '0, 2'd2, 1'b0, e, rd);
    @(posedge clock); #1;
    req_valid = 1'b0;
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_error !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_next_resp got valid=%b rdata=%h err=%b exp 1/%h/0", rsp_valid, rsp_rdata, rsp_error, rd);
    end
  endtask

  task automatic test_random();
    bit e;
    logic [31:0] rd, a, d;
    logic [1:0] s;
    bit w, se;
    int unsigned r;
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 15);
      if (r == 0)      a = BASE - $urandom_range(1, 8);
      else if (r == 1) a = BASE + DEPTH - 4 + $urandom_range(0, 7);
      else             a = BASE + $urandom_range(0, 63);
      s  = 2'($urandom_range(0, 3));
      w  = 1'($urandom_range(0, 1));
      se = 1'($urandom_range(0, 1));
      d  = $urandom;
      issue(w, a, d, s, se, e, rd);
      tests_run++;
      if (rsp_valid !== 1'b1 || rsp_error !== e || rsp_rdata !== rd || err_count !== 8'(model_err)) begin
        tests_failed++;
        $display("FAIL rand[%0d] a=%h s=%0d w=%b got v=%b e=%b d=%h c=%0d exp 1/%b/%h/%0d",
                 k, a, s, w, rsp_valid, rsp_error, rsp_rdata, err_count, e, rd, model_err);
      end
    end
  endtask

  task automatic test_reset_midop();
    bit e;
    logic [31:0] rd;
    issue(1'b1, 32'h1000_0020, 32'h1111_2222, 2'd2, 1'b0, e, rd);
    issue(1'b0, 32'h1000_0020, '0, 2'd2, 1'b0, e, rd);
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h1000_0020;
    req_wdata = 32'hAAAA_AAAA;
    req_size  = 2'd2;
    reset_n   = 1'b0;
    @(posedge clock); #1;
    tests_run++;
    if (rsp_valid !== 1'b0 || err_count !== 8'd0 || rsp_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL midreset_state got valid=%b cnt=%0d rdata=%h exp 0/0/0", rsp_valid, err_count, rsp_rdata);
    end
    reset_n   = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    model_err = 0;
    issue(1'b0, 32'h1000_0020, '0, 2'd2, 1'b0, e, rd);
    tests_run++;
    if (rsp_rdata !== 32'h1111_2222 || rsp_error !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_mem got rdata=%h err=%b exp 11112222/0", rsp_rdata, rsp_error);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_c;
    for (int k = 0; k < 5; k++) begin
      s_valid = 1'b1;
      s_size  = 2'd3;
      @(posedge clock); #1;
      s_valid = 1'b0;
      exp_c = (k + 1 > 3) ? 2'd3 : 2'(k + 1);
      tests_run++;
      if (s_err_count !== exp_c || s_rsp_error !== 1'b1) begin
        tests_failed++;
        $display("FAIL sat[%0d] got cnt=%0d err=%b exp %0d/1", k, s_err_count, s_rsp_error, exp_c);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    init_mem();
    test_word_and_ext();
    test_errors();
    test_backpressure();
    test_random();
    test_reset_midop();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
